// File: rtl/palette_ram_arbiter.sv
// Round-robin arbiter for two requesters sharing RAM port A, with a hardware
// clear sequencer that zero-fills every word of the RAM on command.
module palette_ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in0_rd,
  input  logic                  io_in0_wr,
  input  logic [ADDR_WIDTH-1:0] io_in0_addr,
  input  logic [MASK_WIDTH-1:0] io_in0_mask,
  input  logic [DATA_WIDTH-1:0] io_in0_din,
  output logic                  io_in0_waitReq,
  output logic                  io_in0_valid,
  output logic [DATA_WIDTH-1:0] io_in0_dout,
  input  logic                  io_in1_rd,
  input  logic                  io_in1_wr,
  input  logic [ADDR_WIDTH-1:0] io_in1_addr,
  input  logic [MASK_WIDTH-1:0] io_in1_mask,
  input  logic [DATA_WIDTH-1:0] io_in1_din,
  output logic                  io_in1_waitReq,
  output logic                  io_in1_valid,
  output logic [DATA_WIDTH-1:0] io_in1_dout,
  input  logic                  io_clear,
  output logic                  io_busy,
  output logic                  io_out_rd,
  output logic                  io_out_wr,
  output logic [ADDR_WIDTH-1:0] io_out_addr,
  output logic [MASK_WIDTH-1:0] io_out_mask,
  output logic [DATA_WIDTH-1:0] io_out_din,
  input  logic [DATA_WIDTH-1:0] io_out_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  valid0_q, valid0_d;
  logic                  valid1_q, valid1_d;
  logic                  req0, req1, grant0, grant1, in_clear;

  // last_grant_q = 1 means in1 was served most recently, so in0 wins a tie.
  always_comb begin
    req0           = io_in0_rd | io_in0_wr;
    req1           = io_in1_rd | io_in1_wr;
    in_clear       = (state_q == CLEAR);
    io_in0_waitReq = reset | in_clear | (req1 & ~last_grant_q);
    io_in1_waitReq = reset | in_clear | (req0 & last_grant_q);
    grant0         = req0 & ~io_in0_waitReq;
    grant1         = req1 & ~io_in1_waitReq;

    io_out_rd   = 1'b0;
    io_out_wr   = 1'b0;
    io_out_addr = io_in0_addr;
    io_out_mask = io_in0_mask;
    io_out_din  = io_in0_din;
    if (in_clear) begin
      io_out_wr   = 1'b1;
      io_out_addr = cnt_q;
      io_out_mask = '1;
      io_out_din  = '0;
    end else if (grant1) begin
      io_out_rd   = io_in1_rd & ~io_in1_wr;
      io_out_wr   = io_in1_wr;
      io_out_addr = io_in1_addr;
      io_out_mask = io_in1_mask;
      io_out_din  = io_in1_din;
    end else if (grant0) begin
      io_out_rd   = io_in0_rd & ~io_in0_wr;
      io_out_wr   = io_in0_wr;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    valid0_d     = grant0 & io_in0_rd & ~io_in0_wr;
    valid1_d     = grant1 & io_in1_rd & ~io_in1_wr;
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (io_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Compare before the increment so the counter never relies on wrap.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
    end
  end

  assign io_busy      = in_clear;
  assign io_in0_valid = valid0_q;
  assign io_in1_valid = valid1_q;
  assign io_in0_dout  = io_out_dout;
  assign io_in1_dout  = io_out_dout;

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Directed bench for palette_ram_arbiter: drives both requesters against a
// behavioural 1024x16 byte-masked RAM and checks hand-computed expectations.
module tb_palette_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in0Rd = 1'b0, in0Wr = 1'b0, in1Rd = 1'b0, in1Wr = 1'b0;
   logic [9:0]  in0Addr = '0, in1Addr = '0;
   logic [1:0]  in0Mask = '0, in1Mask = '0;
   logic [15:0] in0Din = '0, in1Din = '0;
   logic        in0WaitReq, in1WaitReq, in0Valid, in1Valid;
   logic [15:0] in0Dout, in1Dout;
   logic        ioClear = 1'b0;
   logic        ioBusy, ioOutRd, ioOutWr;
   logic [9:0]  ioOutAddr;
   logic [1:0]  ioOutMask;
   logic [15:0] ioOutDin;
   logic [15:0] ramDout = '0;

   logic [15:0] mem [0:1023];
   logic        bdFill = 1'b0, bdWrite = 1'b0;
   logic [9:0]  bdAddr = '0;
   logic [15:0] bdData = '0;
   int          writeCount200 = 0;

   int          errorCount = 0;
   int          checkCount = 0;

   // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   palette_ram_arbiter dut (
      .clock(clock), .reset(reset),
      .io_in0_rd(in0Rd), .io_in0_wr(in0Wr), .io_in0_addr(in0Addr),
      .io_in0_mask(in0Mask), .io_in0_din(in0Din),
      .io_in0_waitReq(in0WaitReq), .io_in0_valid(in0Valid), .io_in0_dout(in0Dout),
      .io_in1_rd(in1Rd), .io_in1_wr(in1Wr), .io_in1_addr(in1Addr),
      .io_in1_mask(in1Mask), .io_in1_din(in1Din),
      .io_in1_waitReq(in1WaitReq), .io_in1_valid(in1Valid), .io_in1_dout(in1Dout),
      .io_clear(ioClear), .io_busy(ioBusy),
      .io_out_rd(ioOutRd), .io_out_wr(ioOutWr), .io_out_addr(ioOutAddr),
      .io_out_mask(ioOutMask), .io_out_din(ioOutDin), .io_out_dout(ramDout)
   );

   // Behavioural RAM port A: read-before-write, one-cycle read latency,
   // plus a backdoor for bulk preloads issued from the stimulus thread.
   always @(posedge clock) begin
      if (bdFill) begin
         for (int i = 0; i < 1024; i++) mem[i] = bdData;
      end else if (bdWrite) begin
         mem[bdAddr] = bdData;
      end
      if (ioOutRd) ramDout <= mem[ioOutAddr];
      if (ioOutWr) begin
         if (ioOutMask[0]) mem[ioOutAddr][7:0]  = ioOutDin[7:0];
         if (ioOutMask[1]) mem[ioOutAddr][15:8] = ioOutDin[15:8];
         if (ioOutAddr == 10'h200) writeCount200 = writeCount200 + 1;
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives both requester ports at once.
   task automatic applyStimulus(input logic r0, input logic w0, input logic [9:0] a0,
                                input logic [1:0] m0, input logic [15:0] d0,
                                input logic r1, input logic w1, input logic [9:0] a1,
                                input logic [1:0] m1, input logic [15:0] d1);
      in0Rd = r0; in0Wr = w0; in0Addr = a0; in0Mask = m0; in0Din = d0;
      in1Rd = r1; in1Wr = w1; in1Addr = a1; in1Mask = m1; in1Din = d1;
   endtask

   // Backdoor memory access through the RAM model; returns on a falling edge.
   task automatic backdoor(input logic fill, input logic [9:0] addr, input logic [15:0] data);
      bdFill = fill; bdWrite = ~fill; bdAddr = addr; bdData = data;
      @(posedge clock);
      #1;
      bdFill = 1'b0; bdWrite = 1'b0;
      @(negedge clock);
   endtask

   // Waits out a clear sequence; returns the number of busy cycles seen.
   task automatic runClear(output int busyCycles, output int addrErr,
                           output int waitErr, output int dataErr);
      busyCycles = 0; addrErr = 0; waitErr = 0; dataErr = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (!ioBusy) break;
         if (ioOutAddr !== 10'(busyCycles)) addrErr++;
         if (in0WaitReq !== 1'b1 || in1WaitReq !== 1'b1) waitErr++;
         if (ioOutWr !== 1'b1 || ioOutRd !== 1'b0 || ioOutDin !== 16'h0 || ioOutMask !== 2'b11)
            dataErr++;
         busyCycles++;
         @(negedge clock);
         #1;
      end
   endtask

   function automatic int countNonZero(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (mem[i] !== 16'h0) n++;
      return n;
   endfunction

   initial begin
      int busyCycles, addrErr, waitErr, dataErr;

      $display("[TB] start");
      backdoor(1'b1, 10'h0, 16'h0000);
      backdoor(1'b0, 10'h123, 16'hBEEF);
      backdoor(1'b0, 10'h010, 16'h5A5A);
      backdoor(1'b0, 10'h3FF, 16'hAAAA);

      // Reset state, with a request pending to show waitReq is forced high.
      applyStimulus(1, 0, 10'h123, 2'b00, 16'h0, 1, 0, 10'h010, 2'b00, 16'h0);
      #1;
      checkOutput("reset_waitReq0", 32'(in0WaitReq), 32'h1);
      checkOutput("reset_waitReq1", 32'(in1WaitReq), 32'h1);
      checkOutput("reset_busy", 32'(ioBusy), 32'h0);
      checkOutput("reset_out_rdwr", 32'({ioOutRd, ioOutWr}), 32'h0);
      checkOutput("reset_valid", 32'({in0Valid, in1Valid}), 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Round-robin: in0, in1, in0, in1 with valids one cycle after each grant.
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("rr_waitReq0", 32'(in0WaitReq), 32'(i % 2));
         checkOutput("rr_waitReq1", 32'(in1WaitReq), 32'((i + 1) % 2));
         checkOutput("rr_out_addr", 32'(ioOutAddr), (i % 2 == 0) ? 32'h123 : 32'h010);
         @(negedge clock);
         checkOutput("rr_valid0", 32'(in0Valid), 32'((i + 1) % 2));
         checkOutput("rr_valid1", 32'(in1Valid), 32'(i % 2));
         checkOutput("rr_dout", 32'((i % 2 == 0) ? in0Dout : in1Dout),
                     (i % 2 == 0) ? 32'hBEEF : 32'h5A5A);
      end

      // Single uncontended read.
      applyStimulus(1, 0, 10'h123, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      #1;
      checkOutput("single_waitReq0", 32'(in0WaitReq), 32'h0);
      checkOutput("single_out_rd", 32'(ioOutRd), 32'h1);
      @(negedge clock);
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      checkOutput("single_valid0", 32'(in0Valid), 32'h1);
      checkOutput("single_valid1", 32'(in1Valid), 32'h0);
      checkOutput("single_dout0", 32'(in0Dout), 32'hBEEF);

      // Masked write from in1 over 0xAAAA, read back through in0.
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 1, 10'h3FF, 2'b01, 16'h1234);
      #1;
      checkOutput("mwr_waitReq1", 32'(in1WaitReq), 32'h0);
      checkOutput("mwr_out", 32'({ioOutRd, ioOutWr, ioOutMask}), 32'b0101);
      checkOutput("mwr_out_din", 32'(ioOutDin), 32'h1234);
      @(negedge clock);
      checkOutput("mwr_no_valid", 32'(in1Valid), 32'h0);
      applyStimulus(1, 0, 10'h3FF, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      @(negedge clock);
      checkOutput("mwr_readback", 32'(in0Dout), 32'hAA34);

      // rd and wr together behave as a write only.
      applyStimulus(1, 1, 10'h050, 2'b11, 16'h7777, 0, 0, 10'h0, 2'b00, 16'h0);
      #1;
      checkOutput("rdwr_out", 32'({ioOutRd, ioOutWr}), 32'b01);
      @(negedge clock);
      checkOutput("rdwr_no_valid", 32'(in0Valid), 32'h0);

      // Held request: in1 served last, so in0 wins the tie; in1 waits then goes.
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 1, 0, 10'h010, 2'b00, 16'h0);
      @(negedge clock);
      applyStimulus(1, 0, 10'h123, 2'b00, 16'h0, 0, 1, 10'h200, 2'b11, 16'hCAFE);
      #1;
      checkOutput("held_waitReq0", 32'(in0WaitReq), 32'h0);
      checkOutput("held_waitReq1", 32'(in1WaitReq), 32'h1);
      checkOutput("held_first_addr", 32'(ioOutAddr), 32'h123);
      @(negedge clock);
      checkOutput("held_valid0", 32'(in0Valid), 32'h1);
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 1, 10'h200, 2'b11, 16'hCAFE);
      #1;
      checkOutput("held_waitReq1_go", 32'(in1WaitReq), 32'h0);
      checkOutput("held_out", 32'({ioOutWr, ioOutAddr, ioOutDin}), {5'b0, 1'b1, 10'h200, 16'hCAFE});
      @(negedge clock);
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      @(negedge clock);
      checkOutput("held_ram", 32'(mem[10'h200]), 32'hCAFE);
      checkOutput("held_write_count", 32'(writeCount200), 32'h1);

      // Full clear with in0 reading throughout.
      backdoor(1'b1, 10'h0, 16'hFFFF);
      ioClear = 1'b1;
      applyStimulus(1, 0, 10'h005, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      #1;
      checkOutput("clr_start_grant", 32'(in0WaitReq), 32'h0);
      @(negedge clock);
      ioClear = 1'b0;
      #1;
      checkOutput("clr_overlap_valid", 32'(in0Valid), 32'h1);
      checkOutput("clr_overlap_dout", 32'(in0Dout), 32'hFFFF);
      runClear(busyCycles, addrErr, waitErr, dataErr);
      checkOutput("clr_busy_cycles", 32'(busyCycles), 32'd1024);
      checkOutput("clr_addr_seq", 32'(addrErr), 32'h0);
      checkOutput("clr_waitReq", 32'(waitErr), 32'h0);
      checkOutput("clr_write", 32'(dataErr), 32'h0);
      checkOutput("clr_idle_grant", 32'({in0WaitReq, ioOutRd}), 32'b01);
      @(negedge clock);
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      checkOutput("clr_read_zero", 32'({in0Valid, in0Dout}), 32'h10000);
      checkOutput("clr_mem_zero", 32'(countNonZero(0, 1023)), 32'h0);

      // Reset during clear cycle 500 (counter 499).
      backdoor(1'b1, 10'h0, 16'hFFFF);
      backdoor(1'b0, 10'd600, 16'h6060);
      ioClear = 1'b1;
      @(negedge clock);
      ioClear = 1'b0;
      repeat (499) @(negedge clock);
      #1;
      checkOutput("rmc_addr", 32'(ioOutAddr), 32'd499);
      reset = 1'b1;
      #1;
      checkOutput("rmc_busy", 32'(ioBusy), 32'h0);
      checkOutput("rmc_out_wr", 32'(ioOutWr), 32'h0);
      checkOutput("rmc_waitReq", 32'({in0WaitReq, in1WaitReq}), 32'b11);
      @(negedge clock);
      reset = 1'b0;
      checkOutput("rmc_cleared", 32'(countNonZero(0, 498)), 32'h0);
      checkOutput("rmc_addr499", 32'(mem[499]), 32'hFFFF);
      checkOutput("rmc_addr600", 32'(mem[600]), 32'h6060);
      applyStimulus(1, 0, 10'h001, 2'b00, 16'h0, 1, 0, 10'h002, 2'b00, 16'h0);
      #1;
      checkOutput("rmc_tie_after_reset", 32'({in0WaitReq, in1WaitReq}), 32'b01);
      @(negedge clock);
      applyStimulus(0, 0, 10'h0, 2'b00, 16'h0, 0, 0, 10'h0, 2'b00, 16'h0);
      @(negedge clock);
      ioClear = 1'b1;
      @(negedge clock);
      ioClear = 1'b0;
      #1;
      runClear(busyCycles, addrErr, waitErr, dataErr);
      checkOutput("clr2_busy_cycles", 32'(busyCycles), 32'd1024);
      checkOutput("clr2_addr_seq", 32'(addrErr), 32'h0);
      @(negedge clock);
      checkOutput("clr2_mem_zero", 32'(countNonZero(0, 1023)), 32'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/palette_ram_arbiter.md
# palette_ram_arbiter

Shares the 16-bit, byte-masked port A of a 1024×16 / 512×32 true dual-port RAM between two 16-bit requesters. Typical requesters are the main CPU and a secondary bus master. Includes a hardware clear sequencer that zero-fills the whole RAM on command. Sits between the CPU-side bus decode and the RAM's port A; port B (video read side) is untouched.

## Interface
- ADDR_WIDTH, 10, port A word address width; clear sequencer covers 2^ADDR_WIDTH words.
- DATA_WIDTH, 16, port A data width.
- MASK_WIDTH, 2, byte-mask width (DATA_WIDTH/8).

Ports (clock: `clock`; reset: `reset`, asynchronous, active-high):
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in0_rd / io_in1_rd  in  1  read request.
- io_in0_wr / io_in1_wr  in  1  write request.
- io_inN_addr  in  ADDR_WIDTH  word address.
- io_inN_mask  in  MASK_WIDTH  byte enables for writes.
- io_inN_din  in  DATA_WIDTH  write data.
- io_inN_waitReq  out  1  high = request not accepted this cycle; hold request.
- io_inN_valid  out  1  read data valid strobe.
- io_inN_dout  out  DATA_WIDTH  read data; equals io_out_dout.
- io_clear  in  1  start-clear pulse.
- io_busy  out  1  clear sequencer running.
- io_out_rd / io_out_wr  out  1  to RAM port A.
- io_out_addr  out  ADDR_WIDTH  to RAM port A.
- io_out_mask  out  MASK_WIDTH  to RAM port A.
- io_out_din  out  DATA_WIDTH  to RAM port A.
- io_out_dout  in  DATA_WIDTH  from RAM port A; valid 1 cycle after io_out_rd.

## Operation
- **States:** IDLE, CLEAR. Reset → IDLE.
- **Request:** requester N requests when rd|wr is high. A request is accepted in any cycle where it is asserted and io_inN_waitReq is low. Accept is combinational, zero added latency.
- **Arbitration (IDLE):**
  - One request: granted.
  - Both request: round-robin. The requester not granted most recently wins.
  - Register `lastGrant` updates only on an accepted request. Reset value is 1, so in0 wins the first tie.
- **Granted requester:** its rd, wr, addr, mask and din drive io_out_*. The loser's waitReq is high.
- **No request:** io_out_rd = io_out_wr = 0; other io_out_* are don't-care.
- **rd and wr both high** from one requester: treated as a write only (io_out_rd = 0, no valid).
- **Read return:** io_inN_valid is registered and high exactly 1 cycle after that requester's accepted read. io_inN_dout = io_out_dout combinationally.
- **Clear start:** io_clear high in IDLE → CLEAR next cycle, counter = 0. Normal arbitration still applies in the io_clear cycle.
- **CLEAR state:**
  - Each cycle: io_out_wr = 1, io_out_addr = counter, io_out_mask = all ones, io_out_din = 0; counter increments.
  - Both waitReq high.
  - After writing address 2^ADDR_WIDTH−1, return to IDLE.
  - io_clear is ignored while in CLEAR.
- **io_busy:** high exactly while in CLEAR.
- **Counter width:** ADDR_WIDTH. The final address is detected by compare before wrap, not by overflow.
- **Reset mid-clear:** immediately IDLE, counter 0, busy 0. The RAM is left partially cleared, which is acceptable.
- **Read-data timing:** a read accepted in the last IDLE cycle before CLEAR still gets its valid one cycle later, overlapping the first clear write.

## Timing
- **Reset values:** state IDLE, counter 0, lastGrant 1, io_inN_valid 0, io_busy 0, io_out_rd 0, io_out_wr 0.
- **waitReq during reset:** both high while reset is asserted.
- **Throughput:** one access per cycle total. Two continuously requesting masters alternate every cycle.
- **Read latency:** accept at cycle T → valid and data at T+1.
- **Clear:** io_clear at T → writes at T+1 … T+2^ADDR_WIDTH; busy high over exactly those cycles; IDLE at T+2^ADDR_WIDTH+1.
- **Combinational paths:** in*_rd/wr → waitReq and io_out_* are allowed. No register on the RAM request path.

## Test plan
- **Single read:** preload RAM[0x123] = 0xBEEF; in0 read 0x123, no contention → waitReq0 = 0, io_out_rd = 1 same cycle; valid0 = 1 with dout0 = 0xBEEF next cycle; valid1 stays 0.
- **Masked write:** in1 writes 0x3FF with mask 2'b01 and din 0x1234 over prior 0xAAAA → RAM = 0xAA34; read back through in0 returns 0xAA34.
- **Round-robin:** both hold reads for 4 cycles after reset → grants in0, in1, in0, in1; each valid strobes 1 cycle after its own grant only.
- **Held request:** in1 held while in0 wins, then in0 drops → in1 accepted the next cycle with its original addr and data unchanged; exactly one RAM access per request.
- **Clear:** fill RAM with 0xFFFF, pulse io_clear, hold in0 read requests → busy high for exactly 1024 cycles, waitReq0 high throughout, io_out_addr runs 0..1023; afterwards every address reads 0x0000 and in0 is granted the first IDLE cycle.
- **Reset mid-clear:** assert reset at clear cycle 500 → busy, io_out_wr, valid drop asynchronously; after release addresses 0..498 read 0 and 600 retains its old value; a second io_clear completes normally.
